rv_plic_src_cond: RTL and testbench

//  Interrupt-source conditioning stage directly upstream of the PLIC; drives its intr_src_i.
//  Per source: optional polarity inversion, optional synchronizer, and a glitch filter (debouncer).
//  The filter passes a level change only after it has been stable for FilterCycles cycles.

---
 rtl/rv_plic_reg_pkg.sv | 8 +
 rtl/rv_plic_src_cond_chan.sv | 111 +++++++++++
 rtl/rv_plic_src_cond.sv | 59 +++++
 tb/tb_rv_plic_src_cond.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_plic_reg_pkg.sv
// Register-level constants shared by the PLIC blocks.
// Only the source count is needed by the source-conditioning stage.
package rv_plic_reg_pkg;

  // Number of interrupt sources, including the reserved source 0.
  parameter int NumSrc = 73;

endpackage : rv_plic_reg_pkg

// File: rtl/rv_plic_src_cond_chan.sv
// Single-source conditioning channel.
// Applies optional inversion, an optional synchronizer chain and a glitch filter.
// A level change on the conditioned source reaches src_o only after it has been
// stable for FilterCycles cycles. A run that is abandoned before completion sets
// a sticky glitch flag.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous reset, active-low
//   src_i         raw interrupt line
//   filter_en_i   filter enable (quasi-static); 0 passes the synced level straight through
//   glitch_clr_i  clears the sticky glitch flag at the next edge
//   src_o         conditioned level
//   glitch_o      sticky: a filter run was aborted
module rv_plic_src_cond_chan #(
  parameter bit Async        = 1'b1,
  parameter bit Invert       = 1'b0,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic filter_en_i,
  input  logic glitch_clr_i,
  output logic src_o,
  output logic glitch_o
);

  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  // Elaboration-time parameter sanity.
  if (FilterCycles < 1) begin : g_bad_filter_cycles
    $error("rv_plic_src_cond_chan: FilterCycles must be >= 1");
  end
  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("rv_plic_src_cond_chan: SyncStages must be >= 2");
  end

  // Inversion sits in front of the first flop so the synchronizer and filter
  // always see an active-high level.
  logic x;
  assign x = src_i ^ Invert;

  logic s;

  if (Async) begin : g_sync
    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SyncStages-2:0], x};
      end
    end

    assign s = sync_q[SyncStages-1];
  end else begin : g_no_sync
    // Source already lives in the clk_i domain.
    assign s = x;
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            glitch_q, glitch_d;
  logic            abort;

  // Filter: cnt counts consecutive cycles in which s disagrees with out.
  // Reaching CntLast while still disagreeing commits the new level; an agreement
  // with a non-zero count means the candidate level vanished early.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    abort = 1'b0;
    if (!filter_en_i) begin
      out_d = s;
      cnt_d = '0;
    end else if (s != out_q) begin
      if (cnt_q == CntLast) begin
        out_d = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = '0;
      abort = 1'b1;
    end
  end

  // A new abort takes priority over a coincident clear so no event is lost.
  assign glitch_d = abort | (glitch_q & ~glitch_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      out_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      glitch_q <= glitch_d;
    end
  end

  assign src_o    = out_q;
  assign glitch_o = glitch_q;

endmodule : rv_plic_src_cond_chan

// File: rtl/rv_plic_src_cond.sv
// Interrupt-source conditioning stage directly upstream of the PLIC.
// Each source 1..NumSrc-1 gets its own conditioning channel (inversion,
// synchronizer, glitch filter, sticky glitch flag). Source 0 is reserved by
// the PLIC and is tied low on both outputs.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous reset, active-low
//   intr_src_i    raw interrupt lines
//   filter_en_i   per-source filter enable (quasi-static configuration)
//   glitch_clr_i  per-source clear of the sticky glitch flag
//   intr_src_o    conditioned levels, to the PLIC intr_src_i
//   glitch_o      per-source sticky flag: a filter run was aborted
module rv_plic_src_cond #(
  parameter int                 NumSrc       = rv_plic_reg_pkg::NumSrc,
  parameter int                 SyncStages   = 2,
  parameter logic [NumSrc-1:0]  AsyncMask    = '1,
  parameter logic [NumSrc-1:0]  InvertMask   = '0,
  parameter int                 FilterCycles = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] intr_src_i,
  input  logic [NumSrc-1:0] filter_en_i,
  input  logic [NumSrc-1:0] glitch_clr_i,
  output logic [NumSrc-1:0] intr_src_o,
  output logic [NumSrc-1:0] glitch_o
);

  // Source 0 is reserved: constant outputs, no flops, inputs ignored.
  assign intr_src_o[0] = 1'b0;
  assign glitch_o[0]   = 1'b0;

  logic unused_src0;
  assign unused_src0 = ^{intr_src_i[0], filter_en_i[0], glitch_clr_i[0]};

  for (genvar i = 1; i < NumSrc; i++) begin : g_chan
    rv_plic_src_cond_chan #(
      .Async        (AsyncMask[i]),
      .Invert       (InvertMask[i]),
      .SyncStages   (SyncStages),
      .FilterCycles (FilterCycles)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .src_i        (intr_src_i[i]),
      .filter_en_i  (filter_en_i[i]),
      .glitch_clr_i (glitch_clr_i[i]),
      .src_o        (intr_src_o[i]),
      .glitch_o     (glitch_o[i])
    );
  end

  // Outputs feed the PLIC gateways directly; an X here would poison claims.
  a_outputs_known : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !$isunknown({intr_src_o, glitch_o})
  );

endmodule : rv_plic_src_cond

// File: tb/tb_rv_plic_src_cond.sv
module tb_rv_plic_src_cond;

  localparam int NUM = 73;
  localparam int SS  = 2;
  localparam int FC  = 3;
  localparam logic [NUM-1:0] ASYNC_MASK = ~(73'd1 << 9);
  localparam logic [NUM-1:0] INV_MASK   = 73'd1 << 10;

  logic           clk;
  logic           rst_n;
  logic [NUM-1:0] intr_src;
  logic [NUM-1:0] filter_en;
  logic [NUM-1:0] glitch_clr;
  logic [NUM-1:0] intr_out;
  logic [NUM-1:0] glitch;

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_plic_src_cond #(
    .NumSrc       (NUM),
    .SyncStages   (SS),
    .AsyncMask    (ASYNC_MASK),
    .InvertMask   (INV_MASK),
    .FilterCycles (FC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .intr_src_i   (intr_src),
    .filter_en_i  (filter_en),
    .glitch_clr_i (glitch_clr),
    .intr_src_o   (intr_out),
    .glitch_o     (glitch)
  );

  // ---------------- reference model ----------------
  // Each source: the level seen by the filter is the inverted input delayed by
  // SS cycles (or not delayed for sync sources). The output adopts a new level
  // once that level has differed from it for FC consecutive cycles; a streak
  // broken early marks a glitch.
  logic [NUM-1:0] m_hist [SS];
  logic [NUM-1:0] m_out;
  logic [NUM-1:0] m_gl;
  int             m_streak [NUM];

  function automatic void model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    m_out = '0;
    m_gl  = '0;
    for (int i = 0; i < NUM; i++) m_streak[i] = 0;
  endfunction

  function automatic void model_step();
    logic [NUM-1:0] x;
    logic [NUM-1:0] s;
    bit             broke;
    x = intr_src ^ INV_MASK;
    for (int i = 0; i < NUM; i++) s[i] = ASYNC_MASK[i] ? m_hist[SS-1][i] : x[i];
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = x;
    for (int i = 1; i < NUM; i++) begin
      broke = 1'b0;
      if (!filter_en[i]) begin
        m_out[i]    = s[i];
        m_streak[i] = 0;
      end else if (s[i] != m_out[i]) begin
        m_streak[i] = m_streak[i] + 1;
        if (m_streak[i] == FC) begin
          m_out[i]    = s[i];
          m_streak[i] = 0;
        end
      end else begin
        broke       = (m_streak[i] > 0);
        m_streak[i] = 0;
      end
      if (broke) m_gl[i] = 1'b1;
      else if (glitch_clr[i]) m_gl[i] = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one active edge; returns 1 time unit after it with inputs untouched.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [NUM-1:0] rand_vec(input int one_in);
    logic [NUM-1:0] v;
    for (int i = 0; i < NUM; i++) v[i] = ($urandom_range(0, one_in - 1) == 0);
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    model_reset();
    intr_src   = '1;
    filter_en  = '1;
    glitch_clr = '0;
    #3;
    checks++;
    if (intr_out !== '0) begin
      failures++;
      $display("FAIL reset_out got=%0h exp=0", intr_out);
    end
    checks++;
    if (glitch !== '0) begin
      failures++;
      $display("FAIL reset_glitch got=%0h exp=0", glitch);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (intr_out[0] !== 1'b0) begin
        failures++;
        $display("FAIL reset_src0 edge=%0d got=%b exp=0", k, intr_out[0]);
      end
      checks++;
      if (intr_out[5] !== (k == 4)) begin
        failures++;
        $display("FAIL reset_rise5 edge=%0d got=%b exp=%b", k, intr_out[5], (k == 4));
      end
      checks++;
      if (intr_out !== m_out) begin
        failures++;
        $display("FAIL reset_rise_vec edge=%0d got=%0h exp=%0h", k, intr_out, m_out);
      end
    end
    intr_src = '0;
    settle(8);
  endtask

  task automatic test_filter_pass();
    intr_src[5] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (intr_out[5] !== (k == 4)) begin
        failures++;
        $display("FAIL pass_rise edge=%0d got=%b exp=%b", k, intr_out[5], (k == 4));
      end
    end
    intr_src[5] = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (intr_out[5] !== (k != 4)) begin
        failures++;
        $display("FAIL pass_fall edge=%0d got=%b exp=%b", k, intr_out[5], (k != 4));
      end
    end
    checks++;
    if (glitch[5] !== 1'b0) begin
      failures++;
      $display("FAIL pass_no_glitch got=%b exp=0", glitch[5]);
    end
    settle(2);
  endtask

  task automatic test_glitch();
    intr_src[7] = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k == 2) intr_src[7] = 1'b0;
      step();
      checks++;
      if (intr_out[7] !== 1'b0) begin
        failures++;
        $display("FAIL glitch_out edge=%0d got=%b exp=0", k, intr_out[7]);
      end
      checks++;
      if (glitch[7] !== (k >= 4)) begin
        failures++;
        $display("FAIL glitch_flag edge=%0d got=%b exp=%b", k, glitch[7], (k >= 4));
      end
    end
    glitch_clr[7] = 1'b1;
    step();
    glitch_clr[7] = 1'b0;
    checks++;
    if (glitch[7] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_clear got=%b exp=0", glitch[7]);
    end
    // Second short pulse with the clear landing on the abort edge.
    intr_src[7] = 1'b1;
    step();
    step();
    intr_src[7] = 1'b0;
    step();
    step();
    glitch_clr[7] = 1'b1;
    step();
    glitch_clr[7] = 1'b0;
    checks++;
    if (glitch[7] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_set_wins got=%b exp=1", glitch[7]);
    end
    checks++;
    if (glitch !== m_gl) begin
      failures++;
      $display("FAIL glitch_vec got=%0h exp=%0h", glitch, m_gl);
    end
    glitch_clr[7] = 1'b1;
    step();
    glitch_clr[7] = 1'b0;
    settle(2);
  endtask

  task automatic test_bypass();
    filter_en[9] = 1'b0;
    intr_src[9]  = 1'b1;
    step();
    checks++;
    if (intr_out[9] !== 1'b1) begin
      failures++;
      $display("FAIL bypass_sync_hi got=%b exp=1", intr_out[9]);
    end
    intr_src[9] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (intr_out[9] !== 1'b0) begin
        failures++;
        $display("FAIL bypass_sync_lo edge=%0d got=%b exp=0", k, intr_out[9]);
      end
    end
    filter_en[9] = 1'b1;
    // Async source with the filter off: only the synchronizer delay remains.
    filter_en[11] = 1'b0;
    intr_src[11]  = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      step();
      checks++;
      if (intr_out[11] !== (k == 2)) begin
        failures++;
        $display("FAIL bypass_async edge=%0d got=%b exp=%b", k, intr_out[11], (k == 2));
      end
    end
    intr_src[11] = 1'b0;
    settle(4);
    filter_en[11] = 1'b1;
    checks++;
    if (glitch[11] !== 1'b0) begin
      failures++;
      $display("FAIL bypass_no_glitch got=%b exp=0", glitch[11]);
    end
  endtask

  task automatic test_invert();
    intr_src[10] = 1'b1;
    settle(6);
    checks++;
    if (intr_out[10] !== 1'b0) begin
      failures++;
      $display("FAIL invert_idle got=%b exp=0", intr_out[10]);
    end
    intr_src[10] = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (intr_out[10] !== (k == 4)) begin
        failures++;
        $display("FAIL invert_rise edge=%0d got=%b exp=%b", k, intr_out[10], (k == 4));
      end
    end
  endtask

  task automatic test_reset_midrun();
    intr_src[12] = 1'b1;
    settle(4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (intr_out !== '0) begin
      failures++;
      $display("FAIL midrun_out got=%0h exp=0", intr_out);
    end
    checks++;
    if (glitch !== '0) begin
      failures++;
      $display("FAIL midrun_glitch got=%0h exp=0", glitch);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (intr_out[12] !== (k == 4)) begin
        failures++;
        $display("FAIL midrun_rerise edge=%0d got=%b exp=%b", k, intr_out[12], (k == 4));
      end
    end
    intr_src[12] = 1'b0;
    settle(6);
  endtask

  task automatic test_random();
    apply_reset();
    for (int it = 0; it < 2000; it++) begin
      if (it == 1000) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (intr_out !== '0) begin
          failures++;
          $display("FAIL random_reset got=%0h exp=0", intr_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      intr_src   = intr_src ^ rand_vec(6);
      glitch_clr = rand_vec(12);
      if ($urandom_range(0, 40) == 0) filter_en = ~rand_vec(4);
      step();
      checks++;
      if (intr_out !== m_out) begin
        failures++;
        $display("FAIL random_out it=%0d got=%0h exp=%0h", it, intr_out, m_out);
      end
      checks++;
      if (glitch !== m_gl) begin
        failures++;
        $display("FAIL random_glitch it=%0d got=%0h exp=%0h", it, glitch, m_gl);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    intr_src   = '0;
    filter_en  = '1;
    glitch_clr = '0;
    model_reset();
    test_reset();
    test_filter_pass();
    test_glitch();
    test_bypass();
    test_invert();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rv_plic_src_cond
